// File: rtl/alu_sched_pkg.sv
// Shared types and defaults for the round-robin ALU scheduler.
package alu_sched_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned OP_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] a;
        logic [DATA_W_DEF-1:0] b;
        logic [OP_W_DEF-1:0]   opcode;
        logic                  m;
        logic                  cn;
        logic                  l;
        logic                  h;
    } alu_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after last_grant, with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        // Offsets 1..NUM_REQ visit every requester once, the previous winner last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((32'(last_grant_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between NUM_REQ requesters: round-robin grant, fixed-latency wait,
// then a tagged, backpressured response. One operation in flight at a time.
module alu_rr_scheduler import alu_sched_pkg::*; #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    input  logic [NUM_REQ*OP_W-1:0]   req_opcode_i,
    input  logic [NUM_REQ*4-1:0]      req_ctrl_i,
    output logic [DATA_W-1:0]         alu_a_o,
    output logic [DATA_W-1:0]         alu_b_o,
    output logic [OP_W-1:0]           alu_opcode_o,
    output logic                      alu_m_o,
    output logic                      alu_cn_o,
    output logic                      alu_l_o,
    output logic                      alu_h_o,
    input  logic [DATA_W-1:0]         alu_r_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_data_o
);

    localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    sched_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     last_grant_q;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                load_op;
    logic                capture;

    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [OP_W-1:0]     alu_opcode_q;
    logic [3:0]          alu_ctrl_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_data_q;

    logic [DATA_W-1:0]   sel_a, sel_b;
    logic [OP_W-1:0]     sel_opcode;
    logic [3:0]          sel_ctrl;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    assign sel_a      = req_a_i[grant_idx*DATA_W +: DATA_W];
    assign sel_b      = req_b_i[grant_idx*DATA_W +: DATA_W];
    assign sel_opcode = req_opcode_i[grant_idx*OP_W +: OP_W];
    assign sel_ctrl   = req_ctrl_i[grant_idx*4 +: 4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_op = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    load_op = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(ALU_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ALU drive registers only change on a grant, so they hold between operations.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            alu_ctrl_q   <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
        end else begin
            if (load_op) begin
                last_grant_q <= grant_idx;
                alu_a_q      <= sel_a;
                alu_b_q      <= sel_b;
                alu_opcode_q <= sel_opcode;
                alu_ctrl_q   <= sel_ctrl;
                rsp_id_q     <= grant_idx;
            end
            if (capture) begin
                rsp_data_q <= alu_r_i;
            end
        end
    end

    assign req_ready_o  = (state_q == IDLE) ? grant : '0;
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_id_o     = rsp_id_q;
    assign rsp_data_o   = rsp_data_q;
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_opcode_o = alu_opcode_q;
    assign alu_m_o      = alu_ctrl_q[3];
    assign alu_cn_o     = alu_ctrl_q[2];
    assign alu_l_o      = alu_ctrl_q[1];
    assign alu_h_o      = alu_ctrl_q[0];

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Two scheduler instances (ALU latency 1 and 3) against a transaction-level model,
// plus directed vectors and corner-case sequences.
module tb_alu_rr_scheduler;
    import alu_sched_pkg::*;

    localparam int N    = 4;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   req_valid [2];
    logic [N-1:0]   req_ready [2];
    logic [N*8-1:0] req_a [2];
    logic [N*8-1:0] req_b [2];
    logic [N*4-1:0] req_op [2];
    logic [N*4-1:0] req_ctrl [2];
    logic [7:0]     alu_a [2];
    logic [7:0]     alu_b [2];
    logic [7:0]     alu_r [2];
    logic [3:0]     alu_op [2];
    logic           alu_m [2];
    logic           alu_cn [2];
    logic           alu_l [2];
    logic           alu_h [2];
    logic           rsp_valid [2];
    logic           rsp_ready [2];
    logic [1:0]     rsp_id [2];
    logic [7:0]     rsp_data [2];
    logic           dyn [2];
    int             cyc = 0;

    int tests = 0;
    int fails = 0;

    // Reference model state, one slot per instance.
    bit         busy [2];
    int         rsp_at [2];
    int         last [2];
    int         e_id [2];
    logic [7:0] e_data [2];
    logic [7:0] e_a [2];
    logic [7:0] e_b [2];
    logic [3:0] e_op [2];
    logic [3:0] e_ctrl [2];
    logic [N-1:0] hs [2];
    int         glog0 [$];

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op, input logic m, input logic cn);
        if (m) begin
            case (op)
                4'h6:    return a ^ b;
                4'hB:    return a & b;
                4'hE:    return a | b;
                default: return ~a;
            endcase
        end
        return a + b + {7'd0, cn} + {4'd0, op};
    endfunction

    assign alu_r[0] = alu_f(alu_a[0], alu_b[0], alu_op[0], alu_m[0], alu_cn[0])
                      ^ (dyn[0] ? cyc[7:0] : 8'h00);
    assign alu_r[1] = alu_f(alu_a[1], alu_b[1], alu_op[1], alu_m[1], alu_cn[1])
                      ^ (dyn[1] ? cyc[7:0] : 8'h00);

    always @(posedge clk) cyc <= cyc + 1;

    alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(8), .OP_W(4), .ALU_LAT(LAT0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_a_i(req_a[0]), .req_b_i(req_b[0]), .req_opcode_i(req_op[0]),
        .req_ctrl_i(req_ctrl[0]),
        .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]), .alu_opcode_o(alu_op[0]),
        .alu_m_o(alu_m[0]), .alu_cn_o(alu_cn[0]), .alu_l_o(alu_l[0]), .alu_h_o(alu_h[0]),
        .alu_r_i(alu_r[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_id_o(rsp_id[0]), .rsp_data_o(rsp_data[0])
    );

    alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(8), .OP_W(4), .ALU_LAT(LAT1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_a_i(req_a[1]), .req_b_i(req_b[1]), .req_opcode_i(req_op[1]),
        .req_ctrl_i(req_ctrl[1]),
        .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]), .alu_opcode_o(alu_op[1]),
        .alu_m_o(alu_m[1]), .alu_cn_o(alu_cn[1]), .alu_l_o(alu_l[1]), .alu_h_o(alu_h[1]),
        .alu_r_i(alu_r[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_id_o(rsp_id[1]), .rsp_data_o(rsp_data[1])
    );

    task automatic check(input string name, input int u, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (dut%0d) t=%0t: got %0h, expected %0h", name, u, $time, act, exp);
        end
    endtask

    // Model: grant only when idle, response ALU_LAT+2 cycles after the grant cycle,
    // held until accepted, then one idle cycle before the next grant.
    task automatic mon(input int u);
        int         lat;
        int         win;
        bit         ev;
        logic [N-1:0] er;
        lat = (u == 0) ? LAT0 : LAT1;
        if (!rst_n) begin
            check("rst_alu_a", u, alu_a[u], 0);
            check("rst_alu_b", u, alu_b[u], 0);
            check("rst_alu_op", u, alu_op[u], 0);
            check("rst_alu_ctrl", u, {alu_m[u], alu_cn[u], alu_l[u], alu_h[u]}, 0);
            check("rst_rsp_valid", u, rsp_valid[u], 0);
            check("rst_rsp_id", u, rsp_id[u], 0);
            check("rst_rsp_data", u, rsp_data[u], 0);
            busy[u] = 1'b0;
            last[u] = N - 1;
            e_a[u] = '0; e_b[u] = '0; e_op[u] = '0; e_ctrl[u] = '0;
            hs[u] = '0;
            return;
        end
        ev = busy[u] && (cyc >= rsp_at[u]);
        check("rsp_valid", u, rsp_valid[u], ev);
        if (ev) begin
            check("rsp_id", u, rsp_id[u], e_id[u]);
            check("rsp_data", u, rsp_data[u], e_data[u]);
        end
        check("alu_a", u, alu_a[u], e_a[u]);
        check("alu_b", u, alu_b[u], e_b[u]);
        check("alu_op", u, alu_op[u], e_op[u]);
        check("alu_ctrl", u, {alu_m[u], alu_cn[u], alu_l[u], alu_h[u]}, e_ctrl[u]);
        win = -1;
        if (!busy[u]) begin
            for (int i = 1; i <= N; i++) begin
                int k;
                k = (last[u] + i) % N;
                if (req_valid[u][k]) begin
                    win = k;
                    break;
                end
            end
        end
        er = (win >= 0) ? (N'(1) << win) : '0;
        check("req_ready", u, req_ready[u], er);
        hs[u] = req_ready[u];
        if (win >= 0) begin
            busy[u]   = 1'b1;
            rsp_at[u] = cyc + lat + 2;
            e_id[u]   = win;
            last[u]   = win;
            e_a[u]    = req_a[u][win*8 +: 8];
            e_b[u]    = req_b[u][win*8 +: 8];
            e_op[u]   = req_op[u][win*4 +: 4];
            e_ctrl[u] = req_ctrl[u][win*4 +: 4];
            e_data[u] = alu_f(e_a[u], e_b[u], e_op[u], e_ctrl[u][3], e_ctrl[u][2])
                        ^ (dyn[u] ? 8'(cyc + lat + 1) : 8'h00);
            if (u == 0) glog0.push_back(win);
        end else if (ev && rsp_ready[u]) begin
            busy[u] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) mon(u);
    end

    typedef struct {
        int         id;
        alu_op_t    op;
        logic [7:0] exp;
    } vec_t;

    function automatic vec_t mk(input int id, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] opc, input logic [3:0] ctrl,
                                input logic [7:0] exp);
        vec_t v;
        v.id        = id;
        v.op.a      = a;
        v.op.b      = b;
        v.op.opcode = opc;
        v.op.m      = ctrl[3];
        v.op.cn     = ctrl[2];
        v.op.l      = ctrl[1];
        v.op.h      = ctrl[0];
        v.exp       = exp;
        return v;
    endfunction

    task automatic set_req(input int u, input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] opc, input logic [3:0] ctrl);
        req_a[u][id*8 +: 8]    = a;
        req_b[u][id*8 +: 8]    = b;
        req_op[u][id*4 +: 4]   = opc;
        req_ctrl[u][id*4 +: 4] = ctrl;
        req_valid[u][id]       = 1'b1;
    endtask

    task automatic wait_ready(input int u, input int id);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready[u][id]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("grant_timeout", u, 0, 1);
    endtask

    task automatic wait_rsp(input int u);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rsp_valid[u]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("rsp_timeout", u, 0, 1);
    endtask

    task automatic wait_idle(input int u);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            if (!busy[u]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("idle_timeout", u, 0, 1);
    endtask

    task automatic wait_grants(input int target);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (glog0.size() >= target) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("grant_count_timeout", 0, glog0.size(), target);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        req_valid[0] = '0;
        req_valid[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_single(input int u, input vec_t v, input bit chk_tbl);
        int gcyc;
        int lat;
        lat = (u == 0) ? LAT0 : LAT1;
        @(posedge clk);
        #1;
        set_req(u, v.id, v.op.a, v.op.b, v.op.opcode, {v.op.m, v.op.cn, v.op.l, v.op.h});
        wait_ready(u, v.id);
        gcyc = cyc;
        @(posedge clk);
        #1;
        req_valid[u][v.id] = 1'b0;
        @(negedge clk);
        check("ready_pulse", u, req_ready[u], 0);
        check("issue_a", u, alu_a[u], v.op.a);
        check("issue_b", u, alu_b[u], v.op.b);
        wait_rsp(u);
        check("rsp_latency", u, cyc - gcyc, lat + 2);
        check("tbl_id", u, rsp_id[u], v.id);
        if (chk_tbl) check("tbl_data", u, rsp_data[u], v.exp);
        else check("lat_data", u, rsp_data[u], 8'h26 ^ 8'(gcyc + lat + 1));
        wait_idle(u);
    endtask

    initial begin
        vec_t       vt [5];
        int         exp_f [6];
        int         exp_s [3];
        int         s;
        logic [7:0] held;

        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = '0;
            req_a[u]     = '0;
            req_b[u]     = '0;
            req_op[u]    = '0;
            req_ctrl[u]  = '0;
            rsp_ready[u] = 1'b1;
            dyn[u]       = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ctrl nibble is {m, cn, l, h}
        vt[0] = mk(0, 8'h0F, 8'hF0, 4'h6, 4'b1000, 8'hFF);
        vt[1] = mk(2, 8'h3C, 8'h0F, 4'h6, 4'b1000, 8'h33);
        vt[2] = mk(3, 8'h80, 8'h81, 4'h2, 4'b0100, 8'h04);
        vt[3] = mk(1, 8'hF3, 8'h5A, 4'hB, 4'b1011, 8'h52);
        vt[4] = mk(2, 8'h3C, 8'h00, 4'h0, 4'b1100, 8'hC3);
        for (int i = 0; i < 5; i++) run_single(0, vt[i], 1'b1);

        // Fairness: everyone valid continuously.
        do_reset();
        s = glog0.size();
        exp_f = '{0, 1, 2, 3, 0, 1};
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++)
            set_req(0, k, 8'($urandom), 8'($urandom), 4'($urandom), 4'($urandom));
        wait_grants(s + 6);
        for (int i = 0; i < 6; i++)
            if (glog0.size() > s + i) check("fair_order", 0, glog0[s+i], exp_f[i]);
        @(posedge clk);
        #1;
        req_valid[0] = '0;
        wait_idle(0);

        // Sparse wrap from last_grant = 3.
        do_reset();
        s = glog0.size();
        exp_s = '{1, 3, 1};
        @(posedge clk);
        #1;
        set_req(0, 1, 8'h11, 8'h22, 4'h6, 4'b1000);
        set_req(0, 3, 8'h33, 8'h44, 4'h1, 4'b0001);
        wait_grants(s + 3);
        for (int i = 0; i < 3; i++)
            if (glog0.size() > s + i) check("sparse_order", 0, glog0[s+i], exp_s[i]);
        @(posedge clk);
        #1;
        req_valid[0] = '0;
        wait_idle(0);

        // Backpressure with req2 pending.
        do_reset();
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        set_req(0, 0, 8'hA5, 8'h5A, 4'h6, 4'b1000);
        wait_ready(0, 0);
        @(posedge clk);
        #1;
        req_valid[0][0] = 1'b0;
        set_req(0, 2, 8'h01, 8'h02, 4'h3, 4'b0000);
        wait_rsp(0);
        held = rsp_data[0];
        check("bp_data_first", 0, held, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 0, rsp_valid[0], 1);
            check("bp_ready", 0, req_ready[0], 0);
            check("bp_data", 0, rsp_data[0], held);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_hs_valid", 0, rsp_valid[0], 1);
        check("bp_hs_ready", 0, req_ready[0], 0);
        @(negedge clk);
        check("bp_next_grant", 0, req_ready[0], 4'b0100);
        @(posedge clk);
        #1;
        req_valid[0] = '0;
        wait_idle(0);

        // Reset while waiting on the ALU.
        @(posedge clk);
        #1;
        set_req(0, 1, 8'h77, 8'h88, 4'h6, 4'b1000);
        wait_ready(0, 1);
        @(posedge clk);
        #1;
        req_valid[0] = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req_valid[0] = 4'b0011;
        #1;
        check("mid_rst_alu_a", 0, alu_a[0], 0);
        check("mid_rst_alu_b", 0, alu_b[0], 0);
        check("mid_rst_rsp_valid", 0, rsp_valid[0], 0);
        check("mid_rst_rsp_id", 0, rsp_id[0], 0);
        check("mid_rst_rsp_data", 0, rsp_data[0], 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_first_grant", 0, req_ready[0], 4'b0001);
        @(posedge clk);
        #1;
        req_valid[0] = 4'b0010;
        wait_ready(0, 1);
        @(posedge clk);
        #1;
        req_valid[0] = '0;
        wait_idle(0);

        // Latency sweep with a result that changes every cycle.
        dyn[0] = 1'b1;
        dyn[1] = 1'b1;
        run_single(0, mk(2, 8'h12, 8'h34, 4'h6, 4'b1000, 8'h00), 1'b0);
        run_single(1, mk(2, 8'h12, 8'h34, 4'h6, 4'b1000, 8'h00), 1'b0);

        // Random traffic on both instances.
        for (int t = 0; t < 1500; t++) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                for (int k = 0; k < N; k++) begin
                    if (req_valid[u][k]) begin
                        if (hs[u][k]) req_valid[u][k] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        set_req(u, k, 8'($urandom), 8'($urandom), 4'($urandom),
                                4'($urandom));
                    end
                end
                rsp_ready[u] = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = '0;
            rsp_ready[u] = 1'b1;
        end
        wait_idle(0);
        wait_idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
